// File: rtl/fir_stream_ctrl.sv
// Stream front/back end for a free-running 5-tap FIR: frames in, TAPS-1 zero flush, tagged
// capture, optional divide-by-10 normalizer (FIR_CTRL_NORM_EN), FWFT output FIFO.
//   state   | meaning
//   S_IDLE  | waiting for first sample of a frame
//   S_RUN   | accepting frame samples until s_last
//   S_FLUSH | injecting TAPS-1 tagged zeros to finish the convolution
//   S_DRAIN | waiting for tagged results still in the filter/normalizer
module fir_stream_ctrl #(
  parameter int signalSize = 32,
  parameter int TAPS       = 5,
  parameter int FILT_LAT   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic [signalSize-1:0] s_data,
  output logic [signalSize-1:0] f_in,
  input  logic [signalSize-1:0] f_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [signalSize-1:0] m_data,
  output logic                  busy,
  output logic                  underrun
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;
  logic                  underrun_q, underrun_d;
  logic                  en_q;
  logic [FILT_LAT-1:0]   tag_q, tag_last_q;
  logic                  tag_in, tag_last_in;
  logic [CW-1:0]         inflight, norm_busy, fifo_cnt_q;
  logic [CW:0]           occ;
  logic                  have_space, accept;
  logic                  push, push_last, pop, fifo_full;
  logic [signalSize-1:0] push_data;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [signalSize:0]   mem [FIFO_DEPTH];
  logic [signalSize:0]   rd_word;

`ifdef FIR_CTRL_NORM_EN
  // Unsigned /10 as multiply by ceil(2^(N+3)/10) and shift; exact for magnitudes up to 2^N-1.
  localparam logic [2*signalSize+3:0] RECIP =
    ((2*signalSize+4)'(1) << (signalSize + 3)) / 10 + 1;

  logic                    n1_v_q, n1_neg_q, n1_last_q;
  logic                    n2_v_q, n2_last_q;
  logic [signalSize-1:0]   n1_mag_q, n2_data_q, quot;
  logic [2*signalSize+3:0] prod;

  always_comb begin
    prod = {{(signalSize+4){1'b0}}, n1_mag_q} * RECIP;
    quot = signalSize'(prod >> (signalSize + 3));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n1_v_q    <= 1'b0;
      n1_neg_q  <= 1'b0;
      n1_last_q <= 1'b0;
      n1_mag_q  <= '0;
      n2_v_q    <= 1'b0;
      n2_last_q <= 1'b0;
      n2_data_q <= '0;
    end else begin
      n1_v_q    <= tag_q[FILT_LAT-1];
      n1_last_q <= tag_last_q[FILT_LAT-1];
      n1_neg_q  <= f_out[signalSize-1];
      n1_mag_q  <= f_out[signalSize-1] ? -f_out : f_out;
      n2_v_q    <= n1_v_q;
      n2_last_q <= n1_last_q;
      n2_data_q <= n1_neg_q ? -quot : quot;
    end
  end

  assign norm_busy = CW'(n1_v_q) + CW'(n2_v_q);
  assign push      = n2_v_q;
  assign push_last = n2_last_q;
  assign push_data = n2_data_q;
`else
  assign norm_busy = '0;
  assign push      = tag_q[FILT_LAT-1];
  assign push_last = tag_last_q[FILT_LAT-1];
  assign push_data = f_out;
`endif

  always_comb begin
    inflight = norm_busy;
    for (int i = 0; i < FILT_LAT; i++)
      inflight = inflight + CW'(tag_q[i]);
  end

  // Every tag issued is guaranteed a FIFO slot, so the FIFO can never overflow.
  assign occ        = {1'b0, fifo_cnt_q} + {1'b0, inflight};
  assign have_space = (occ < (CW+1)'(FIFO_DEPTH));
  assign s_ready    = en_q && (state_q == S_IDLE || state_q == S_RUN) && have_space;
  assign accept     = s_valid && s_ready;
  assign f_in       = accept ? s_data : '0;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    underrun_d  = underrun_q;
    tag_in      = 1'b0;
    tag_last_in = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept) begin
          tag_in = 1'b1;
          if (s_last) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FCW'(TAPS - 1);
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_RUN) begin
          underrun_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (have_space) begin
          tag_in      = 1'b1;
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FCW'(1)) begin
            tag_last_in = 1'b1;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (inflight == '0)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      underrun_q  <= 1'b0;
      en_q        <= 1'b0;
      tag_q       <= '0;
      tag_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      underrun_q  <= underrun_d;
      en_q        <= 1'b1;
      tag_q       <= {tag_q[FILT_LAT-2:0], tag_in};
      tag_last_q  <= {tag_last_q[FILT_LAT-2:0], tag_last_in};
    end
  end

  assign fifo_full = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign m_valid   = (fifo_cnt_q != '0);
  assign pop       = m_valid && m_ready;
  assign rd_word   = mem[rd_ptr_q];
  assign m_data    = m_valid ? rd_word[signalSize-1:0] : '0;
  assign m_last    = m_valid && rd_word[signalSize];
  assign busy      = (state_q != S_IDLE) || (inflight != '0) || m_valid;
  assign underrun  = underrun_q;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= {push_last, push_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule
